// File: rtl/fibonacci_checker.sv
// fibonacci_checker: checks that a valid/ready stream carries the Fibonacci
// sequence 1, 1, 2, 3, 5, ... (mod 2^W), one or two terms per beat.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous restart; drops any beat offered this cycle
//   in_valid/in_ready input handshake (in_ready is combinational)
//   in_data           LANES*W bits, lane 0 in [W-1:0] is the earlier term
//   res_valid/ready   result handshake; res_match is high when every lane matched
//   term_count        saturating count of matched terms
//   error, wrapped    sticky mismatch / carry-out-of-W status
module fibonacci_checker #(
    parameter int unsigned W     = 16,
    parameter int unsigned LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_match,
    output logic [15:0]          term_count,
    output logic                 error,
    output logic                 wrapped
);

    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   exp_a_q, exp_a_d;
    logic [W-1:0]   exp_b_q, exp_b_d;
    logic           ca_q, ca_d;
    logic           cb_q, cb_d;
    logic [CW-1:0]  count_q, count_d;
    logic           res_valid_q, res_valid_d;
    logic           res_match_q, res_match_d;
    logic           error_q, error_d;
    logic           wrapped_q, wrapped_d;

    logic [2*W-1:0] data_pad;
    logic [W-1:0]   lane0;
    logic [W-1:0]   lane1;
    logic           accept;
    logic           m0;
    logic           m1;
    logic [W:0]     sum_ab;
    logic [W+1:0]   sum_abb;
    logic [1:0]     inc;
    logic [CW:0]    cnt_sum;

    // Handshake: clear drops the offered beat; a pending result blocks unless taken now.
    assign in_ready = !clear && (!res_valid_q || res_ready);
    assign accept   = in_valid && in_ready;

    // Pad to two lanes so lane 1 is always addressable; unused when LANES == 1.
    assign data_pad = (2*W)'(in_data);
    assign lane0    = data_pad[W-1:0];
    assign lane1    = data_pad[2*W-1:W];

    assign m0 = (lane0 == exp_a_q);
    assign m1 = (LANES == 1) || (lane1 == exp_b_q);

    // Next-term sums with their carries: a+b, and a+2b for the double-rate step.
    assign sum_ab  = (W+1)'(exp_a_q) + (W+1)'(exp_b_q);
    assign sum_abb = (W+2)'(exp_a_q) + (W+2)'(exp_b_q) + (W+2)'(exp_b_q);

    // Saturating add of the matched-lane count.
    assign cnt_sum = (CW+1)'(count_q) + (CW+1)'(inc);

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        exp_a_d     = exp_a_q;
        exp_b_d     = exp_b_q;
        ca_d        = ca_q;
        cb_d        = cb_q;
        count_d     = count_q;
        res_valid_d = res_valid_q;
        res_match_d = res_match_q;
        error_d     = error_q;
        wrapped_d   = wrapped_q;
        inc         = 2'd0;

        if (clear) begin
            state_d     = ST_IDLE;
            exp_a_d     = W'(1);
            exp_b_d     = W'(1);
            ca_d        = 1'b0;
            cb_d        = 1'b0;
            count_d     = '0;
            res_valid_d = 1'b0;
            res_match_d = 1'b0;
            error_d     = 1'b0;
            wrapped_d   = 1'b0;
        end else begin
            if (res_valid_q && res_ready) begin
                res_valid_d = 1'b0;
            end
            if (accept) begin
                res_valid_d = 1'b1;
                res_match_d = 1'b0;
                unique case (state_q)
                    ST_IDLE, ST_RUN: begin
                        if (m0 && m1) begin
                            state_d     = ST_RUN;
                            res_match_d = 1'b1;
                            inc         = 2'(LANES);
                            if (LANES == 1) begin
                                exp_a_d   = exp_b_q;
                                exp_b_d   = sum_ab[W-1:0];
                                ca_d      = cb_q;
                                cb_d      = sum_ab[W];
                                wrapped_d = wrapped_q | ca_q;
                            end else begin
                                exp_a_d   = sum_ab[W-1:0];
                                exp_b_d   = sum_abb[W-1:0];
                                ca_d      = sum_ab[W];
                                cb_d      = |sum_abb[W+1:W];
                                wrapped_d = wrapped_q | ca_q | cb_q;
                            end
                        end else begin
                            state_d = ST_FAIL;
                            error_d = 1'b1;
                            // Lane 0 good, lane 1 bad: the good term still counts.
                            if (m0) begin
                                inc       = 2'd1;
                                wrapped_d = wrapped_q | ca_q;
                            end
                        end
                    end
                    ST_FAIL: begin
                        state_d = ST_FAIL;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
                if (inc != 2'd0) begin
                    count_d = cnt_sum[CW] ? {CW{1'b1}} : cnt_sum[CW-1:0];
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            exp_a_q     <= W'(1);
            exp_b_q     <= W'(1);
            ca_q        <= 1'b0;
            cb_q        <= 1'b0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            error_q     <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_a_q     <= exp_a_d;
            exp_b_q     <= exp_b_d;
            ca_q        <= ca_d;
            cb_q        <= cb_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_match_q <= res_match_d;
            error_q     <= error_d;
            wrapped_q   <= wrapped_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_match  = res_match_q;
    assign term_count = count_q;
    assign error      = error_q;
    assign wrapped    = wrapped_q;

endmodule
